// File: rtl/pe_bitserial_mac.sv
// Bit-serial signed multiply-accumulate stage of the PE.
// Consumes one activation bit per cycle and hands the partial sum downstream over valid/ready.
module pe_bitserial_mac #(
    parameter int ACT_WIDTH = 16,
    parameter int WGT_WIDTH = 8,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 acc_clear,
    input  logic [ACT_WIDTH-1:0] act_in,
    input  logic [WGT_WIDTH-1:0] wgt_in,
    input  logic [CNT_WIDTH-1:0] n_bits,
    output logic                 busy,
    output logic [ACC_WIDTH-1:0] psum_out,
    output logic                 psum_valid,
    input  logic                 psum_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [ACC_WIDTH-1:0]   acc_r, acc_nxt_s;
    logic [ACT_WIDTH-1:0]   act_r, act_nxt_s;
    logic [ACC_WIDTH-1:0]   wgt_r, wgt_nxt_s;
    logic [CNT_WIDTH-1:0]   n_r, n_nxt_s;
    logic [CNT_WIDTH-1:0]   bit_r, bit_nxt_s;
    logic                   valid_r, valid_nxt_s;
    logic                   busy_r, busy_nxt_s;
    logic [ACC_WIDTH-1:0]   wgt_sh_s;
    logic                   last_s;

    // Zero or oversize precision requests fall back to the full activation width.
    function automatic logic [CNT_WIDTH-1:0] eff_n(input logic [CNT_WIDTH-1:0] n);
        if ((n == {CNT_WIDTH{1'b0}}) || (n > CNT_WIDTH'(ACT_WIDTH))) begin
            return CNT_WIDTH'(ACT_WIDTH);
        end else begin
            return n;
        end
    endfunction

    // Weight aligned to the current activation bit; bits shifted past the accumulator are dropped.
    always_comb begin
        wgt_sh_s = wgt_r << bit_r;
        last_s   = (bit_r == (n_r - CNT_WIDTH'(1)));
    end

    // Next-state and datapath update for the IDLE/RUN/HOLD sequencer.
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        act_nxt_s   = act_r;
        wgt_nxt_s   = wgt_r;
        n_nxt_s     = n_r;
        bit_nxt_s   = bit_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    act_nxt_s   = act_in;
                    wgt_nxt_s   = {{(ACC_WIDTH-WGT_WIDTH){wgt_in[WGT_WIDTH-1]}}, wgt_in};
                    n_nxt_s     = eff_n(n_bits);
                    bit_nxt_s   = {CNT_WIDTH{1'b0}};
                    state_nxt_s = RUN;
                    if (acc_clear) begin
                        acc_nxt_s = {ACC_WIDTH{1'b0}};
                    end else begin
                        acc_nxt_s = acc_r;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                // The top used bit is the two's-complement sign, so it subtracts.
                if (act_r[0]) begin
                    if (last_s) begin
                        acc_nxt_s = acc_r - wgt_sh_s;
                    end else begin
                        acc_nxt_s = acc_r + wgt_sh_s;
                    end
                end else begin
                    acc_nxt_s = acc_r;
                end
                act_nxt_s = act_r >> 1;
                bit_nxt_s = bit_r + CNT_WIDTH'(1);
                if (last_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HOLD: begin
                if (psum_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        valid_nxt_s = (state_nxt_s == HOLD);
        busy_nxt_s  = (state_nxt_s != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= {ACC_WIDTH{1'b0}};
            act_r   <= {ACT_WIDTH{1'b0}};
            wgt_r   <= {ACC_WIDTH{1'b0}};
            n_r     <= {CNT_WIDTH{1'b0}};
            bit_r   <= {CNT_WIDTH{1'b0}};
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            acc_r   <= acc_nxt_s;
            act_r   <= act_nxt_s;
            wgt_r   <= wgt_nxt_s;
            n_r     <= n_nxt_s;
            bit_r   <= bit_nxt_s;
            valid_r <= valid_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign psum_out   = acc_r;
    assign psum_valid = valid_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_pe_bitserial_mac.sv
// Self-checking bench for pe_bitserial_mac: directed cases plus random operations
// compared against an integer multiply-accumulate reference.
module tb_pe_bitserial_mac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        acc_clear = 1'b0;
    logic [15:0] act_in = 16'd0;
    logic [7:0]  wgt_in = 8'd0;
    logic [4:0]  n_bits = 5'd0;
    logic        busy;
    logic [23:0] psum_out;
    logic        psum_valid;
    logic        psum_ready = 1'b0;

    int          errors = 0;
    int          checks = 0;
    logic [23:0] exp_acc = 24'd0;

    pe_bitserial_mac dut (
        .clk(clk), .rst(rst), .start(start), .acc_clear(acc_clear),
        .act_in(act_in), .wgt_in(wgt_in), .n_bits(n_bits), .busy(busy),
        .psum_out(psum_out), .psum_valid(psum_valid), .psum_ready(psum_ready)
    );

    always #5 clk = ~clk;

    function automatic int eff_n(input logic [4:0] n);
        return ((n == 5'd0) || (n > 5'd16)) ? 16 : int'(n);
    endfunction

    // acc + weight * (low ne bits of act as a signed number), modulo 2^24
    function automatic logic [23:0] model(input logic [23:0] acc, input logic [7:0] w,
                                          input logic [15:0] a, input int ne);
        longint av, wv, p;
        av = longint'({48'd0, a}) & ((longint'(1) << ne) - 1);
        if (av >= (longint'(1) << (ne - 1))) av = av - (longint'(1) << ne);
        wv = longint'(signed'(w));
        p  = longint'({40'd0, acc}) + wv * av;
        return p[23:0];
    endfunction

    task automatic wait_valid(input int ne, input string tag);
        int cnt = 0;
        while (psum_valid !== 1'b1 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++;
        if (cnt != ne) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, expected %0d", tag, cnt, ne);
        end
    endtask

    task automatic run_op(input logic clr, input logic [7:0] w, input logic [15:0] a,
                          input logic [4:0] n, input logic rdy_run, input int rdelay,
                          input string tag);
        int ne;
        ne = eff_n(n);
        exp_acc = model(clr ? 24'd0 : exp_acc, w, a, ne);
        @(negedge clk);
        start = 1'b1; acc_clear = clr; wgt_in = w; act_in = a; n_bits = n;
        psum_ready = rdy_run;
        @(posedge clk); #1;
        checks++;
        if ({busy, psum_valid} !== 2'b10) begin
            errors++;
            $display("FAIL %s_accept: busy,valid=%b expected 10", tag, {busy, psum_valid});
        end
        @(negedge clk);
        start = 1'b0; act_in = 16'($urandom); wgt_in = 8'($urandom);
        n_bits = 5'($urandom); acc_clear = 1'($urandom);
        wait_valid(ne, tag);
        checks++;
        if (psum_out !== exp_acc) begin
            errors++;
            $display("FAIL %s_psum: got %h expected %h", tag, psum_out, exp_acc);
        end
        for (int i = 0; i < rdelay; i++) begin
            @(negedge clk); psum_ready = 1'b0;
            @(posedge clk); #1;
            checks++;
            if ({busy, psum_valid} !== 2'b11 || psum_out !== exp_acc) begin
                errors++;
                $display("FAIL %s_hold: busy,valid=%b psum=%h expected 11 %h",
                         tag, {busy, psum_valid}, psum_out, exp_acc);
            end
        end
        @(negedge clk); psum_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, psum_valid} !== 2'b00) begin
            errors++;
            $display("FAIL %s_xfer: busy,valid=%b expected 00", tag, {busy, psum_valid});
        end
        @(negedge clk); psum_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, psum_valid} !== 2'b00 || psum_out !== 24'h000000) begin
            errors++;
            $display("FAIL reset: busy,valid=%b psum=%h expected 00 000000", {busy, psum_valid}, psum_out);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy, psum_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: busy,valid=%b expected 00", {busy, psum_valid});
        end
    endtask

    task automatic test_basic();
        run_op(1'b1, 8'h03, 16'h0005, 5'd4, 1'b1, 0, "basic");
        checks++;
        if (psum_out !== 24'h00000F) begin
            errors++;
            $display("FAIL basic_const: got %h expected 00000f", psum_out);
        end
    endtask

    task automatic test_signed();
        run_op(1'b1, 8'hFE, 16'h000D, 5'd4, 1'b0, 1, "signed");
        checks++;
        if (psum_out !== 24'h000006) begin
            errors++;
            $display("FAIL signed_const: got %h expected 000006", psum_out);
        end
        run_op(1'b0, 8'h01, 16'h0007, 5'd4, 1'b0, 0, "accum");
        checks++;
        if (psum_out !== 24'h00000D) begin
            errors++;
            $display("FAIL accum_const: got %h expected 00000d", psum_out);
        end
    endtask

    task automatic test_full_precision();
        run_op(1'b1, 8'h01, 16'h8000, 5'd0, 1'b0, 0, "fullprec");
        checks++;
        if (psum_out !== 24'hFF8000) begin
            errors++;
            $display("FAIL fullprec_const: got %h expected ff8000", psum_out);
        end
        run_op(1'b1, 8'h83, 16'hA5C3, 5'd27, 1'b0, 0, "oversize_n");
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start = 1'b1; acc_clear = 1'b1; wgt_in = 8'h05; act_in = 16'h0007; n_bits = 5'd4;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, psum_valid} !== 2'b00 || psum_out !== 24'h000000) begin
            errors++;
            $display("FAIL midrun_reset: busy,valid=%b psum=%h expected 00 000000", {busy, psum_valid}, psum_out);
        end
        @(negedge clk); rst = 1'b0;
        exp_acc = 24'd0;
        run_op(1'b0, 8'h01, 16'h0001, 5'd4, 1'b0, 0, "after_reset");
        checks++;
        if (psum_out !== 24'h000001) begin
            errors++;
            $display("FAIL after_reset_const: got %h expected 000001", psum_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] first;
        exp_acc = model(24'd0, 8'h11, 16'h0123, 12);
        first = exp_acc;
        @(negedge clk);
        start = 1'b1; acc_clear = 1'b1; wgt_in = 8'h11; act_in = 16'h0123; n_bits = 5'd12;
        @(posedge clk); #1;
        @(negedge clk);
        acc_clear = 1'b0; wgt_in = 8'hF3; act_in = 16'h00B5; n_bits = 5'd9;
        wait_valid(12, "bp_first");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, psum_valid} !== 2'b11 || psum_out !== first) begin
                errors++;
                $display("FAIL bp_stall: busy,valid=%b psum=%h expected 11 %h", {busy, psum_valid}, psum_out, first);
            end
        end
        @(negedge clk); psum_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, psum_valid} !== 2'b00 || psum_out !== first) begin
            errors++;
            $display("FAIL bp_xfer: busy,valid=%b psum=%h expected 00 %h", {busy, psum_valid}, psum_out, first);
        end
        @(negedge clk); psum_ready = 1'b0;
        exp_acc = model(first, 8'hF3, 16'h00B5, 9);
        @(posedge clk); #1;
        checks++;
        if ({busy, psum_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_pending_start: busy,valid=%b expected 10", {busy, psum_valid});
        end
        @(negedge clk); start = 1'b0;
        wait_valid(9, "bp_second");
        checks++;
        if (psum_out !== exp_acc) begin
            errors++;
            $display("FAIL bp_second_psum: got %h expected %h", psum_out, exp_acc);
        end
        @(negedge clk); psum_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); psum_ready = 1'b0;
    endtask

    task automatic test_wrap();
        run_op(1'b1, 8'h80, 16'h8000, 5'd16, 1'b0, 0, "wrap_a");
        run_op(1'b0, 8'h80, 16'h8000, 5'd16, 1'b0, 0, "wrap_b");
        run_op(1'b0, 8'hFF, 16'h0001, 5'd2, 1'b0, 0, "wrap_c");
        checks++;
        if (psum_out !== 24'h7FFFFF) begin
            errors++;
            $display("FAIL wrap_preload: got %h expected 7fffff", psum_out);
        end
        run_op(1'b0, 8'h01, 16'h0001, 5'd2, 1'b0, 0, "wrap");
        checks++;
        if (psum_out !== 24'h800000) begin
            errors++;
            $display("FAIL wrap_const: got %h expected 800000", psum_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_op(1'($urandom), 8'($urandom), 16'($urandom), 5'($urandom_range(0, 31)),
                   1'($urandom), int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_full_precision();
        test_reset_mid_run();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pe_bitserial_mac.md
Name: pe_bitserial_mac

Overview:
- Bit-serial multiply-accumulate stage inside the PE.
- Multiplies a signed weight by a signed activation one activation bit per cycle, accumulating into a partial-sum register.
- Presents the finished partial sum to the downstream PE mux/enable register stage over a valid/ready handshake.
- Variable activation precision (n_bits) trades cycles for accuracy.

Parameters:
ACT_WIDTH, 16, maximum activation width in bits (signed two's complement)
WGT_WIDTH, 8, weight width in bits (signed two's complement)
ACC_WIDTH, 24, partial-sum accumulator width
CNT_WIDTH, 5, bit-counter width; must hold values 0..ACT_WIDTH

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new MAC operation; sampled only in IDLE
acc_clear  input  1  sampled with start; 1 = accumulator starts from 0, 0 = accumulate onto the held value
act_in  input  ACT_WIDTH  activation operand, latched on accepted start
wgt_in  input  WGT_WIDTH  weight operand, latched on accepted start
n_bits  input  CNT_WIDTH  activation precision; 1..ACT_WIDTH valid; 0 or >ACT_WIDTH treated as ACT_WIDTH
busy  output  1  high in RUN and HOLD
psum_out  output  ACC_WIDTH  accumulator value; valid while psum_valid
psum_valid  output  1  result available to downstream
psum_ready  input  1  downstream accepts result

Behaviour:
- Reset (async, any state): FSM to IDLE. acc, psum_out, psum_valid, busy, the activation shift register, latched weight and bit counter all go to 0.
- States: IDLE, RUN, HOLD.
- IDLE, start=1 at an edge:
  - latch act_in into the shift register and sign-extend wgt_in to ACC_WIDTH;
  - latch effective n (after the 0/out-of-range mapping); clear the bit index;
  - if acc_clear=1, set acc to 0; otherwise keep acc;
  - go to RUN; busy rises after this edge.
- RUN, each edge, with b = current bit index (0..n-1) and LSB the current activation bit:
  - if LSB=1 and b<n-1: acc <= acc + (wgt_ext << b);
  - if LSB=1 and b=n-1: acc <= acc - (wgt_ext << b) (sign bit has negative weight);
  - shift the activation register right by 1 and increment b.
  - On the edge that processes b=n-1, go to HOLD and assert psum_valid.
- Timing: an operation accepted at edge k has psum_valid high after edge k+n. Exactly n RUN cycles, with no zero-skipping.
- Arithmetic: all adds and subtracts are modulo 2^ACC_WIDTH (wrap, no saturation). Shifted weight bits above ACC_WIDTH are discarded.
- Only the low n bits of act_in are used; bit n-1 is the sign bit.
- HOLD:
  - psum_out = acc and stays stable;
  - psum_valid stays high until an edge with psum_ready=1; that edge goes to IDLE and drops psum_valid.
  - acc keeps its value for a later accumulation with acc_clear=0.
- psum_ready=1 while psum_valid=0 has no effect.
- start is ignored in RUN and HOLD, including during the HOLD->IDLE transfer edge. A new start is accepted no earlier than the first cycle in IDLE, so the minimum gap between results is n+1 cycles.
- psum_out is driven from acc at all times; it is meaningful only when psum_valid=1.
- Reset mid-RUN or mid-HOLD: the result is discarded, no psum_valid pulse occurs, and acc=0.

Test Plan:
- rst pulse mid-RUN (wgt=5, act=7, n=4, released after 2 RUN cycles) -> psum_valid=0, busy=0, psum_out=0x000000 immediately; the next start with acc_clear=0, wgt=1, act=1, n=4 gives psum_out=1.
- start, acc_clear=1, wgt=3, act=5, n_bits=4, psum_ready=1 -> psum_valid high exactly 4 cycles after the start edge, psum_out=0x00000F, then IDLE the next cycle.
- Signed: acc_clear=1, wgt=0xFE (-2), act=0xD (-3), n_bits=4 -> psum_out=0x000006. Then acc_clear=0, wgt=0x01, act=0x7, n=4 -> psum_out=0x00000D.
- Full precision via n_bits=0: acc_clear=1, wgt=0x01, act=0x8000 -> 16 RUN cycles, psum_out=0xFF8000.
- Backpressure: psum_ready=0 for 6 cycles after psum_valid with start held high -> psum_valid and psum_out stable, busy=1, no new operation. psum_ready=1 -> one transfer, then the pending start is accepted on the following IDLE cycle.
- Wrap: preload acc=0x7FFFFF (acc_clear=1, wgt=0x7F, act chosen to sum to 0x7FFFFF, or a repeated accumulation sequence), then acc_clear=0, wgt=1, act=1, n=2 -> psum_out=0x800000 (wrapped).
